alu_seq: RTL and testbench

// - Parametrised multi-cycle ALU; next generation of the combinational 8-bit ALU.
// - Adds a valid/ready handshake on input and output, an iterative MUL, and a

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_seq_mul.sv | 57 +++++
 rtl/alu_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and control-state encodings.
package alu_pkg;

  // Operation select. The encoding matches the opcode bus bit-for-bit.
  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_ADDI = 3'b001,
    OP_XOR  = 3'b010,
    OP_ADD  = 3'b011,
    OP_MUL  = 3'b100,
    OP_SHV  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SHF  = 3'b111
  } alu_op_e;

  // Control FSM: IDLE accepts, BUSY iterates (MUL / SHV), DONE holds the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH steps.
// start_i loads the operands; done_o is high during the final step, and
// product_o then carries the complete 2*WIDTH-bit product for that cycle.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_o    = busy_q && (cnt_q == CNT_W'(1));
    product_o = acc_step;
  end

  // Operand load on start, then one step per cycle until the count runs out.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CNT_W'(WIDTH);
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete straight from IDLE; MUL and non-zero SHV iterate in BUSY.
// Result and zero/carry/parity flags are registered together and held in DONE.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMM_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             parity
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int SHF_W   = IMM_W - 1;

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               parity_q, parity_d;

  // Variable-shift working state.
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [SHAMT_W-1:0] sh_cnt_q, sh_cnt_d;
  logic               sh_right_q, sh_right_d;
  logic               mul_op_q, mul_op_d;

  alu_op_e            op;
  logic [SHAMT_W-1:0] shv_amt;
  logic [SHF_W-1:0]   shf_amt;

  logic [WIDTH:0]     sum_w, addi_w, diff_w, shl_w, shr_w;
  logic [WIDTH-1:0]   single_res;
  logic               single_carry;
  logic [WIDTH-1:0]   step_res;
  logic               step_carry;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic               fin_valid;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_carry;

  assign op      = alu_op_e'(opcode);
  assign shv_amt = operand2[SHAMT_W-1:0];
  assign shf_amt = imm[SHF_W-1:0];

  // Extra top bit captures carry-out, borrow, or the last bit shifted out.
  assign sum_w  = {1'b0, operand1} + {1'b0, operand2};
  assign addi_w = {1'b0, operand1} + (WIDTH+1)'(imm);
  assign diff_w = {1'b0, operand1} - {1'b0, operand2};
  assign shl_w  = {1'b0, operand1} << shf_amt;
  assign shr_w  = {operand1, 1'b0} >> shf_amt;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign parity    = parity_q;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .Clk       (Clk),
    .Reset     (Reset),
    .start_i   (mul_start),
    .a_i       (operand1),
    .b_i       (operand2),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Result and carry of the ops that finish in the accept cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    single_res   = '0;
    single_carry = 1'b0;
    case (op)
      OP_AND:  single_res = operand1 & operand2;
      OP_ADDI: {single_carry, single_res} = addi_w;
      OP_XOR:  single_res = operand1 ^ operand2;
      OP_ADD:  {single_carry, single_res} = sum_w;
      OP_SUB:  {single_carry, single_res} = diff_w;
      OP_SHF: begin
        if (imm[IMM_W-1]) begin
          single_res   = shr_w[WIDTH:1];
          single_carry = shr_w[0];
        end else begin
          {single_carry, single_res} = shl_w;
        end
      end
      default: ;
    endcase
  end

  // One-bit step of the variable shift; the bit leaving the register is the carry.
  always_comb begin
    if (sh_right_q) begin
      step_res   = sh_q >> 1;
      step_carry = sh_q[0];
    end else begin
      step_res   = sh_q << 1;
      step_carry = sh_q[WIDTH-1];
    end
  end

  // Next-state logic, operation dispatch and result/flag capture.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    parity_d   = parity_q;
    sh_d       = sh_q;
    sh_cnt_d   = sh_cnt_q;
    sh_right_d = sh_right_q;
    mul_op_d   = mul_op_q;
    mul_start  = 1'b0;
    fin_valid  = 1'b0;
    fin_res    = '0;
    fin_carry  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (op)
            OP_MUL: begin
              mul_start = 1'b1;
              mul_op_d  = 1'b1;
              state_d   = BUSY;
            end
            OP_SHV: begin
              if (shv_amt == '0) begin
                fin_valid = 1'b1;
                fin_res   = operand1;
              end else begin
                sh_d       = operand1;
                sh_cnt_d   = shv_amt;
                sh_right_d = operand2[WIDTH-1];
                mul_op_d   = 1'b0;
                state_d    = BUSY;
              end
            end
            default: begin
              fin_valid = 1'b1;
              fin_res   = single_res;
              fin_carry = single_carry;
            end
          endcase
        end
      end
      BUSY: begin
        if (mul_op_q) begin
          if (mul_done) begin
            fin_valid = 1'b1;
            fin_res   = mul_product[WIDTH-1:0];
            fin_carry = |mul_product[2*WIDTH-1:WIDTH];
          end
        end else begin
          sh_d     = step_res;
          sh_cnt_d = sh_cnt_q - SHAMT_W'(1);
          if (sh_cnt_q == SHAMT_W'(1)) begin
            fin_valid = 1'b1;
            fin_res   = step_res;
            fin_carry = step_carry;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flags are derived from the final result so they are registered alongside it.
    if (fin_valid) begin
      state_d  = DONE;
      result_d = fin_res;
      carry_d  = fin_carry;
      zero_d   = (fin_res == '0);
      parity_d = ^fin_res;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Result, flag and shift-working registers.
  always_ff @(posedge Clk) begin
    // NOTE: these are plain registers, not a memory, so all of them reset; the visible result and flags must read zero after reset.
    if (Reset) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      parity_q   <= 1'b0;
      sh_q       <= '0;
      sh_cnt_q   <= '0;
      sh_right_q <= 1'b0;
      mul_op_q   <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      parity_q   <= parity_d;
      sh_q       <= sh_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_right_q <= sh_right_d;
      mul_op_q   <= mul_op_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8, IMM_W=3): directed scenarios plus
// randomized operations compared against an arithmetic reference model.
module tb_alu_seq;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    opcode;
  logic [W-1:0]  operand1;
  logic [W-1:0]  operand2;
  logic [IW-1:0] imm;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          carry;
  logic          parity;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  alu_seq #(.WIDTH(W), .IMM_W(IW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .operand1  (operand1),
    .operand2  (operand2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .parity    (parity)
  );

  // Logical shift of a by n using integer arithmetic; c is the last bit shifted out.
  function automatic void ref_shift(input int a, input int n, input bit right,
                                    output int r, output int c);
    int m;
    int full;
    m = 1 << W;
    if (right) begin
      r = a >> n;
      c = (n > 0) ? ((a >> (n - 1)) & 1) : 0;
    end else begin
      full = a << n;
      r = full % m;
      c = (n > 0) ? ((full >> W) & 1) : 0;
    end
  endfunction

  // Reference model: result, carry and latency (cycles from accept to out_valid).
  function automatic void ref_op(input int op, input int a, input int b, input int im,
                                 output int r, output int c, output int lat);
    int m;
    int full;
    int n;
    m   = 1 << W;
    r   = 0;
    c   = 0;
    lat = 1;
    case (op)
      0: r = a & b;
      1: begin full = a + im; r = full % m; c = (full >= m) ? 1 : 0; end
      2: r = a ^ b;
      3: begin full = a + b; r = full % m; c = (full >= m) ? 1 : 0; end
      4: begin full = a * b; r = full % m; c = (full >= m) ? 1 : 0; lat = W + 1; end
      5: begin
        n = b % W;
        ref_shift(a, n, b >= m / 2, r, c);
        lat = n + 1;
      end
      6: begin r = (a - b + m) % m; c = (a < b) ? 1 : 0; end
      default: begin
        n = im % (1 << (IW - 1));
        ref_shift(a, n, im >= (1 << (IW - 1)), r, c);
      end
    endcase
  endfunction

  // Issue one request from IDLE, wait (bounded) for out_valid, capture, then release.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [IW-1:0] im, input int hold,
                        output logic [W-1:0] r, output logic c, output logic z,
                        output logic p, output int lat);
    opcode   = op;
    operand1 = a;
    operand2 = b;
    imm      = im;
    in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    operand1 = W'($urandom_range(0, 255));
    operand2 = W'($urandom_range(0, 255));
    imm      = IW'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL op_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
    end
    r = result;
    c = carry;
    z = zero;
    p = parity;
    repeat (hold) begin @(posedge Clk); #1; end
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = '0;
    operand1  = '0;
    operand2  = '0;
    imm       = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, result, zero, carry, parity} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b res=%h z=%b c=%b p=%b, required rdy=1 vld=0 res=00 flags=000",
               in_ready, out_valid, result, zero, carry, parity);
    end
  endtask

  task automatic test_add_wrap();
    logic [W-1:0] r; logic c, z, p; int lat;
    run_op(3'b011, 8'hFF, 8'h01, 3'd0, 0, r, c, z, p, lat);
    n_checks++;
    if (lat !== 1) begin
      n_fail++; $display("FAIL add_latency: got %0d, required 1", lat);
    end
    n_checks++;
    if ({r, z, c, p} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL add_ff_01: res=%h z=%b c=%b p=%b, required 00 1 1 0", r, z, c, p);
    end
  endtask

  // SUB, then hold out_ready low for 5 cycles while pushing a competing request.
  task automatic test_sub_backpressure();
    int lat;
    opcode = 3'b110; operand1 = 8'h03; operand2 = 8'h05; in_valid = 1'b1;
    @(posedge Clk); #1;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge Clk); #1; lat++; end
    n_checks++;
    if (lat !== 1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL sub_latency: got %0d vld=%b, required 1 vld=1", lat, out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, in_ready, result, carry, zero, parity} !== {1'b1, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL sub_hold[%0d]: vld=%b rdy=%b res=%h c=%b z=%b p=%b, required 1 0 FE 1 0 1",
                 i, out_valid, in_ready, result, carry, zero, parity);
      end
      opcode   = 3'($urandom_range(0, 7));
      operand1 = W'($urandom_range(0, 255));
      operand2 = W'($urandom_range(0, 255));
      @(posedge Clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL release_to_idle: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] r; logic c, z, p; int lat;
    run_op(3'b100, 8'h12, 8'h10, 3'd0, 0, r, c, z, p, lat);
    n_checks++;
    if (lat !== 9) begin
      n_fail++; $display("FAIL mul_latency: got %0d, required 9", lat);
    end
    n_checks++;
    if ({r, c} !== {8'h20, 1'b1}) begin
      n_fail++; $display("FAIL mul_12x10: res=%h c=%b, required 20 1", r, c);
    end
    run_op(3'b100, 8'h0F, 8'h11, 3'd0, 1, r, c, z, p, lat);
    n_checks++;
    if ({r, c, z, p} !== {8'hFF, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mul_0fx11: res=%h c=%b z=%b p=%b, required FF 0 0 0", r, c, z, p);
    end
  endtask

  task automatic test_shifts();
    logic [W-1:0] r; logic c, z, p; int lat;
    run_op(3'b101, 8'h81, 8'h03, 3'd0, 0, r, c, z, p, lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL shv_latency: got %0d, required 4", lat);
    end
    n_checks++;
    if ({r, c} !== {8'h08, 1'b0}) begin
      n_fail++; $display("FAIL shv_left3: res=%h c=%b, required 08 0", r, c);
    end
    run_op(3'b101, 8'h5A, 8'h80, 3'd0, 0, r, c, z, p, lat);
    n_checks++;
    if (lat !== 1 || {r, c} !== {8'h5A, 1'b0}) begin
      n_fail++; $display("FAIL shv_amount0: lat=%0d res=%h c=%b, required 1 5A 0", lat, r, c);
    end
    run_op(3'b111, 8'h81, 8'h00, 3'b101, 0, r, c, z, p, lat);
    n_checks++;
    if (lat !== 1 || {r, c} !== {8'h40, 1'b1}) begin
      n_fail++; $display("FAIL shf_right1: lat=%0d res=%h c=%b, required 1 40 1", lat, r, c);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [W-1:0] r; logic c, z, p; int lat;
    opcode = 3'b100; operand1 = 8'hAB; operand2 = 8'hCD; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    n_checks++;
    if ({out_valid, result, in_ready, zero, carry, parity} !== {1'b0, 8'h00, 1'b1, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid_mul: vld=%b res=%h rdy=%b z=%b c=%b p=%b, required 0 00 1 0 0 0",
               out_valid, result, in_ready, zero, carry, parity);
    end
    run_op(3'b000, 8'hF0, 8'h3C, 3'd0, 0, r, c, z, p, lat);
    n_checks++;
    if ({lat == 1, r, c, z, p} !== {1'b1, 8'h30, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL and_after_reset: lat=%0d res=%h c=%b z=%b p=%b, required 1 30 0 0 0", lat, r, c, z, p);
    end
  endtask

  // MUL with a noisy request port throughout BUSY and DONE.
  task automatic test_busy_noise();
    int er, ec, el, lat;
    logic [W-1:0] a, b;
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
    ref_op(4, int'(a), int'(b), 0, er, ec, el);
    opcode = 3'b100; operand1 = a; operand2 = b; in_valid = 1'b1;
    @(posedge Clk); #1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL busy_in_ready: got %b at cycle %0d, required 0", in_ready, lat);
      end
      opcode   = 3'($urandom_range(0, 7));
      operand1 = W'($urandom_range(0, 255));
      operand2 = W'($urandom_range(0, 255));
      in_valid = $urandom_range(0, 1) != 0;
      @(posedge Clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (lat !== el || {result, carry} !== {W'(er), ec[0]}) begin
      n_fail++;
      $display("FAIL busy_noise_mul %h*%h: lat=%0d res=%h c=%b, required %0d %h %0d", a, b, lat, result, carry, el, er, ec);
    end
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] r, a, b; logic c, z, p; logic [2:0] op; logic [IW-1:0] im;
    int er, ec, el, lat;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom_range(0, 255));
      b  = W'($urandom_range(0, 255));
      im = IW'($urandom_range(0, 7));
      ref_op(int'(op), int'(a), int'(b), int'(im), er, ec, el);
      run_op(op, a, b, im, $urandom_range(0, 2), r, c, z, p, lat);
      n_checks++;
      if (lat !== el) begin
        n_fail++; $display("FAIL rand_latency[%0d] op=%0d a=%h b=%h: got %0d, required %0d", i, op, a, b, lat, el);
      end
      n_checks++;
      if ({r, c, z, p} !== {W'(er), ec[0], er == 0, 1'($countones(er) % 2)}) begin
        n_fail++;
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h imm=%0d: res=%h c=%b z=%b p=%b, required res=%h c=%0d",
                 i, op, a, b, im, r, c, z, p, er, ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub_backpressure();
    test_mul();
    test_shifts();
    test_reset_mid_mul();
    test_busy_noise();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
